// File: rtl/addsub_multicycle_pkg.sv
// Shared definitions for the multi-cycle add/subtract engine: state encoding
// and the slice-count / counter-width helpers used to size the top level.
package addsub_multicycle_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int calc_nchunk(input int width, input int chunk);
    return (chunk < 1) ? 1 : width / chunk;
  endfunction

  // A single-slice configuration still needs a 1-bit counter to keep ranges legal.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/addsub_multicycle_add_chunk.sv
// Combinational W-bit ripple adder for one slice; also exposes the carry into
// its top bit so the caller can form signed overflow on the final slice.
module add_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb_in
);

  logic [W:0] carry;

  always_comb begin
    // NOTE: every output of a combinational block gets a value before any
    // conditional logic, otherwise synthesis infers a latch to hold it.
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < W; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end
    cout     = carry[W];
    c_msb_in = carry[W-1];
  end

endmodule

// File: rtl/addsub_multicycle.sv
// Multi-cycle two's-complement add/subtract: one CHUNK-bit slice per clock,
// LSB first, with start/ready request and valid/ack result handshakes.
module addsub_multicycle
  import addsub_multicycle_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             CTRL,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             READY,
  output logic             VALID,
  input  logic             ACK,
  output logic [WIDTH-1:0] S,
  output logic             C_OUT,
  output logic             OVF,
  output logic             ZERO,
  output logic             NEG
);

  if (CHUNK < 1) begin : g_bad_chunk
    $fatal(1, "addsub_multicycle: CHUNK must be at least 1");
  end else if (WIDTH % CHUNK != 0) begin : g_bad_width
    $fatal(1, "addsub_multicycle: WIDTH must be a multiple of CHUNK");
  end

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int CW     = cnt_width(NCHUNK);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;

  int               slice_lsb;
  logic [CHUNK-1:0] a_slice, b_slice, sum_slice;
  logic             cout_slice, cmsb_slice;

  assign slice_lsb = CHUNK * int'(cnt_q);
  assign a_slice   = a_q[slice_lsb +: CHUNK];
  assign b_slice   = b_q[slice_lsb +: CHUNK];

  add_chunk #(.W(CHUNK)) u_add (
    .a        (a_slice),
    .b        (b_slice),
    .cin      (carry_q),
    .sum      (sum_slice),
    .cout     (cout_slice),
    .c_msb_in (cmsb_slice)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    s_d     = s_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    neg_d   = neg_q;

    unique case (state_q)
      ST_IDLE: begin
        // Subtraction is A + ~B + 1: invert B once here, seed the carry with CTRL.
        if (START) begin
          a_d     = A;
          b_d     = B ^ {WIDTH{CTRL}};
          carry_d = CTRL;
          cnt_d   = '0;
          res_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        res_d[slice_lsb +: CHUNK] = sum_slice;
        carry_d = cout_slice;
        cnt_d   = cnt_q + CW'(1);
        // The visible result only changes once the whole word is assembled.
        if (cnt_q == LAST) begin
          s_d     = res_d;
          c_out_d = cout_slice;
          ovf_d   = cout_slice ^ cmsb_slice;
          zero_d  = (res_d == '0);
          neg_d   = res_d[WIDTH-1];
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (ACK) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      s_q     <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample its _d value from
      // before the edge, so update order inside this block does not matter.
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      s_q     <= s_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  assign READY = (state_q == ST_IDLE);
  assign VALID = (state_q == ST_DONE);
  assign S     = s_q;
  assign C_OUT = c_out_q;
  assign OVF   = ovf_q;
  assign ZERO  = zero_q;
  assign NEG   = neg_q;

endmodule

// File: tb/tb_addsub_multicycle.sv
// Directed-vector bench for addsub_multicycle at 16/4, 32/8 and 16/16
// configurations; expected results are hand-computed constants.
module tb_addsub_multicycle;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  // 16-bit, 4-bit slices
  logic        st0 = 0, ct0 = 0, ak0 = 0;
  logic [15:0] a0 = '0, b0 = '0;
  logic        rd0, vl0, co0, ov0, zr0, ng0;
  logic [15:0] s0;
  // 32-bit, 8-bit slices
  logic        st1 = 0, ct1 = 0, ak1 = 0;
  logic [31:0] a1 = '0, b1 = '0;
  logic        rd1, vl1, co1, ov1, zr1, ng1;
  logic [31:0] s1;
  // 16-bit, single slice
  logic        st2 = 0, ct2 = 0, ak2 = 0;
  logic [15:0] a2 = '0, b2 = '0;
  logic        rd2, vl2, co2, ov2, zr2, ng2;
  logic [15:0] s2;

  int n_vec = 0;
  int n_err = 0;

  addsub_multicycle #(.WIDTH(16), .CHUNK(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(st0), .CTRL(ct0), .A(a0), .B(b0),
    .READY(rd0), .VALID(vl0), .ACK(ak0), .S(s0),
    .C_OUT(co0), .OVF(ov0), .ZERO(zr0), .NEG(ng0)
  );

  addsub_multicycle #(.WIDTH(32), .CHUNK(8)) dut_w32 (
    .CLK(CLK), .RST_N(RST_N), .START(st1), .CTRL(ct1), .A(a1), .B(b1),
    .READY(rd1), .VALID(vl1), .ACK(ak1), .S(s1),
    .C_OUT(co1), .OVF(ov1), .ZERO(zr1), .NEG(ng1)
  );

  addsub_multicycle #(.WIDTH(16), .CHUNK(16)) dut_c16 (
    .CLK(CLK), .RST_N(RST_N), .START(st2), .CTRL(ct2), .A(a2), .B(b2),
    .READY(rd2), .VALID(vl2), .ACK(ak2), .S(s2),
    .C_OUT(co2), .OVF(ov2), .ZERO(zr2), .NEG(ng2)
  );

  // Issue one operation, scramble operands after acceptance, and return the
  // number of edges from acceptance until VALID (capped at 40 on timeout).
  task automatic op_any(input int which, input logic [31:0] a, input logic [31:0] b,
                        input logic ctrl, output int lat);
    logic v;
    @(negedge CLK);
    case (which)
      0: begin a0 = a[15:0]; b0 = b[15:0]; ct0 = ctrl; st0 = 1'b1; end
      1: begin a1 = a;       b1 = b;       ct1 = ctrl; st1 = 1'b1; end
      default: begin a2 = a[15:0]; b2 = b[15:0]; ct2 = ctrl; st2 = 1'b1; end
    endcase
    @(posedge CLK);
    @(negedge CLK);
    st0 = 0; st1 = 0; st2 = 0;
    a0 = ~a0; b0 = ~b0; ct0 = ~ct0;
    a1 = ~a1; b1 = ~b1; ct1 = ~ct1;
    a2 = ~a2; b2 = ~b2; ct2 = ~ct2;
    lat = 0;
    do begin
      @(posedge CLK);
      lat++;
      #1;
      v = (which == 0) ? vl0 : (which == 1) ? vl1 : vl2;
    end while (!v && lat < 40);
  endtask

  task automatic ack_any(input int which);
    @(negedge CLK);
    case (which)
      0: ak0 = 1'b1;
      1: ak1 = 1'b1;
      default: ak2 = 1'b1;
    endcase
    @(posedge CLK);
    #1;
    ak0 = 0; ak1 = 0; ak2 = 0;
  endtask

  task automatic test_reset;
    #2;
    n_vec++; if ({rd0, vl0} !== 2'b10) begin n_err++; $display("FAIL reset_rdy_vld: got %b want 10", {rd0, vl0}); end
    n_vec++; if (s0 !== 16'h0000) begin n_err++; $display("FAIL reset_s: got %h want 0000", s0); end
    n_vec++; if ({co0, ov0, zr0, ng0} !== 4'b0000) begin n_err++; $display("FAIL reset_flags: got %b want 0000", {co0, ov0, zr0, ng0}); end
    n_vec++; if ({rd1, vl1, rd2, vl2} !== 4'b1010) begin n_err++; $display("FAIL reset_other_cfgs: got %b want 1010", {rd1, vl1, rd2, vl2}); end
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_basic_add;
    int lat;
    op_any(0, 32'h0005, 32'h0003, 1'b0, lat);
    n_vec++; if (lat !== 4) begin n_err++; $display("FAIL add_latency: got %0d want 4", lat); end
    n_vec++; if (s0 !== 16'h0008) begin n_err++; $display("FAIL add_s: got %h want 0008", s0); end
    n_vec++; if ({co0, ov0, zr0, ng0} !== 4'b0000) begin n_err++; $display("FAIL add_flags: got %b want 0000", {co0, ov0, zr0, ng0}); end
    ack_any(0);
    n_vec++; if ({rd0, vl0} !== 2'b10) begin n_err++; $display("FAIL add_after_ack: got %b want 10", {rd0, vl0}); end
  endtask

  task automatic test_signed;
    int lat;
    op_any(0, 32'h7FFF, 32'h0001, 1'b0, lat);
    n_vec++; if (s0 !== 16'h8000) begin n_err++; $display("FAIL ovf_s: got %h want 8000", s0); end
    n_vec++; if ({co0, ov0, zr0, ng0} !== 4'b0101) begin n_err++; $display("FAIL ovf_flags: got %b want 0101", {co0, ov0, zr0, ng0}); end
    ack_any(0);
    op_any(0, 32'hFFF6, 32'hFFF1, 1'b0, lat);
    n_vec++; if (s0 !== 16'hFFE7) begin n_err++; $display("FAIL negadd_s: got %h want ffe7", s0); end
    n_vec++; if ({co0, ov0, zr0, ng0} !== 4'b1001) begin n_err++; $display("FAIL negadd_flags: got %b want 1001", {co0, ov0, zr0, ng0}); end
    ack_any(0);
  endtask

  task automatic test_subtract;
    int lat;
    op_any(0, 32'h0003, 32'h0008, 1'b1, lat);
    n_vec++; if (s0 !== 16'hFFFB) begin n_err++; $display("FAIL sub_borrow_s: got %h want fffb", s0); end
    n_vec++; if ({co0, ov0, zr0, ng0} !== 4'b0001) begin n_err++; $display("FAIL sub_borrow_flags: got %b want 0001", {co0, ov0, zr0, ng0}); end
    ack_any(0);
    op_any(0, 32'h0008, 32'h0008, 1'b1, lat);
    n_vec++; if (s0 !== 16'h0000) begin n_err++; $display("FAIL sub_zero_s: got %h want 0000", s0); end
    n_vec++; if ({co0, ov0, zr0, ng0} !== 4'b1010) begin n_err++; $display("FAIL sub_zero_flags: got %b want 1010", {co0, ov0, zr0, ng0}); end
    ack_any(0);
  endtask

  task automatic test_handshake;
    int w;
    @(negedge CLK);
    a0 = 16'h0100; b0 = 16'h0011; ct0 = 1'b0; st0 = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    // Second request, changed operands and a stray ACK, all while running.
    a0 = 16'h1234; b0 = 16'h1234; ct0 = 1'b1; ak0 = 1'b1;
    n_vec++; if (rd0 !== 1'b0) begin n_err++; $display("FAIL run_ready: got %b want 0", rd0); end
    @(negedge CLK);
    st0 = 1'b0; ak0 = 1'b0;
    w = 0;
    while (!vl0 && w < 40) begin @(negedge CLK); w++; end
    n_vec++; if (vl0 !== 1'b1) begin n_err++; $display("FAIL hs_valid: got %b want 1", vl0); end
    n_vec++; if (s0 !== 16'h0111) begin n_err++; $display("FAIL hs_s: got %h want 0111", s0); end
    // START during DONE must also be ignored.
    st0 = 1'b1; a0 = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      n_vec++;
      if ({vl0, rd0, s0} !== {2'b10, 16'h0111}) begin
        n_err++; $display("FAIL hold_%0d: got vld/rdy/s %b %h want 10 0111", i, {vl0, rd0}, s0);
      end
    end
    st0 = 1'b0;
    ack_any(0);
    n_vec++; if ({vl0, rd0} !== 2'b01) begin n_err++; $display("FAIL hs_ack: got vld/rdy %b want 01", {vl0, rd0}); end
    n_vec++; if (s0 !== 16'h0111) begin n_err++; $display("FAIL hs_s_kept: got %h want 0111", s0); end
  endtask

  task automatic test_back_to_back;
    int lat;
    op_any(0, 32'h1111, 32'h2222, 1'b0, lat);
    n_vec++; if (s0 !== 16'h3333) begin n_err++; $display("FAIL b2b_first: got %h want 3333", s0); end
    ack_any(0);
    op_any(0, 32'h5000, 32'h0001, 1'b1, lat);
    n_vec++; if (lat !== 4) begin n_err++; $display("FAIL b2b_latency: got %0d want 4", lat); end
    n_vec++; if ({s0, co0, ov0, zr0, ng0} !== {16'h4FFF, 4'b1000}) begin
      n_err++; $display("FAIL b2b_second: got %h/%b want 4fff/1000", s0, {co0, ov0, zr0, ng0});
    end
    ack_any(0);
  endtask

  task automatic test_reset_mid;
    int lat;
    @(negedge CLK);
    a0 = 16'h0F0F; b0 = 16'h0101; ct0 = 1'b0; st0 = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    st0 = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    n_vec++; if ({rd0, vl0} !== 2'b10) begin n_err++; $display("FAIL midrst_rdy_vld: got %b want 10", {rd0, vl0}); end
    n_vec++; if ({s0, co0, ov0, zr0, ng0} !== 20'h0) begin
      n_err++; $display("FAIL midrst_s_flags: got %h/%b want 0000/0000", s0, {co0, ov0, zr0, ng0});
    end
    @(negedge CLK);
    RST_N = 1'b1;
    op_any(0, 32'h0002, 32'h0002, 1'b0, lat);
    n_vec++; if (lat !== 4) begin n_err++; $display("FAIL midrst_latency: got %0d want 4", lat); end
    n_vec++; if (s0 !== 16'h0004) begin n_err++; $display("FAIL midrst_s: got %h want 0004", s0); end
    ack_any(0);
  endtask

  task automatic test_param;
    int lat;
    op_any(1, 32'hFFFFFFFF, 32'h00000001, 1'b0, lat);
    n_vec++; if (lat !== 4) begin n_err++; $display("FAIL w32_latency: got %0d want 4", lat); end
    n_vec++; if ({s1, co1, ov1, zr1, ng1} !== {32'h0, 4'b1010}) begin
      n_err++; $display("FAIL w32_wrap: got %h/%b want 00000000/1010", s1, {co1, ov1, zr1, ng1});
    end
    ack_any(1);
    op_any(1, 32'h7FFFFFFF, 32'h00000001, 1'b0, lat);
    n_vec++; if ({s1, co1, ov1, zr1, ng1} !== {32'h80000000, 4'b0101}) begin
      n_err++; $display("FAIL w32_ovf: got %h/%b want 80000000/0101", s1, {co1, ov1, zr1, ng1});
    end
    ack_any(1);
    op_any(2, 32'h0005, 32'h0003, 1'b0, lat);
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL c16_latency: got %0d want 1", lat); end
    n_vec++; if ({s2, co2, ov2, zr2, ng2} !== {16'h0008, 4'b0000}) begin
      n_err++; $display("FAIL c16_add: got %h/%b want 0008/0000", s2, {co2, ov2, zr2, ng2});
    end
    ack_any(2);
    op_any(2, 32'h0003, 32'h0008, 1'b1, lat);
    n_vec++; if ({s2, co2, ov2, zr2, ng2} !== {16'hFFFB, 4'b0001}) begin
      n_err++; $display("FAIL c16_sub: got %h/%b want fffb/0001", s2, {co2, ov2, zr2, ng2});
    end
    ack_any(2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_add();
    test_signed();
    test_subtract();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    test_param();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/addsub_multicycle.md
Name: addsub_multicycle

Overview:
Parametrised successor to the 16-bit two's-complement add/subtract unit. Operates over multiple cycles, processing one CHUNK-bit slice per clock from LSB to MSB, with a carry register between slices. Uses a start/ready and valid/ack handshake and produces a full flag set (carry, overflow, zero, negative). Sits in the datapath of the multi-cycle RISC core as the ALU add/sub engine, where a narrow adder that is reused over several cycles saves area.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits added per cycle; NCHUNK = WIDTH/CHUNK slice cycles per operation.

Ports:
CLK  input  1  system clock, rising-edge.
RST_N  input  1  asynchronous active-low reset.
START  input  1  request; accepted only when READY=1.
CTRL  input  1  0 = A+B, 1 = A-B (B inverted, carry-in 1).
A  input  WIDTH  operand A, sampled on acceptance.
B  input  WIDTH  operand B, sampled on acceptance.
READY  output  1  high only in IDLE.
VALID  output  1  result valid; held until ACK.
ACK  input  1  consumer accepts result.
S  output  WIDTH  sum/difference.
C_OUT  output  1  carry out of the MSB (in subtract mode, 1 = no borrow).
OVF  output  1  signed overflow = carry into MSB XOR carry out of MSB.
ZERO  output  1  S == 0.
NEG  output  1  S[WIDTH-1].

Behaviour:
- Reset (RST_N=0, asynchronous): state=IDLE; READY=1; VALID=0; S=0; C_OUT=OVF=ZERO=NEG=0; internal operand, carry and counter registers cleared.
- States: IDLE, RUN, DONE.
- IDLE: on START=1 at the clock edge, latch A, B XOR {WIDTH{CTRL}}, carry=CTRL, count=0; go to RUN. READY drops in the cycle after acceptance.
- RUN: each edge adds slice[count] of A and B' plus the carry register; writes the result into the matching S slice; updates the carry. After the NCHUNK-th slice edge (count=NCHUNK-1): register C_OUT, OVF, ZERO and NEG from the completed result; go to DONE; VALID=1.
- Latency: acceptance edge k, result and VALID visible after edge k+NCHUNK (4 cycles at the defaults).
- DONE: VALID=1 and S/flags stable while ACK=0. When ACK=1 at an edge, go to IDLE with VALID=0 and READY=1 next cycle. S and flags keep their last values until the next operation completes.
- START while READY=0 (RUN or DONE) is ignored; no queueing. Operand changes after acceptance have no effect.
- ACK outside DONE is ignored.
- RST_N asserted in any state, including mid-RUN: immediately aborts to the reset values; a partial S is never presented.
- OVF is computed from the carry into the top bit, which is captured during the final slice.
- Arithmetic wraps modulo 2^WIDTH.
- Elaboration: WIDTH % CHUNK != 0 or CHUNK < 1 is an error (fatal check).

Decomposition:
- Shared package/header: state encoding localparams (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2); NCHUNK calculation and counter-width helper (clog2).
- Sub-module add_chunk: combinational CHUNK-bit ripple adder. Inputs a, b, cin; outputs sum, cout, and c_msb_in (carry into its top bit, used for OVF).
- The top level holds the FSM, counter, operand and carry registers, and the flag logic.

Test Plan:
1. Reset and basic add: after reset READY=1, VALID=0, S=0000. Then A=0005, B=0003, CTRL=0, START pulse -> VALID after exactly 4 edges; S=0008, C_OUT=0, OVF=0, ZERO=0, NEG=0.
2. Signed cases: A=7FFF, B=0001, CTRL=0 -> S=8000, OVF=1, NEG=1, C_OUT=0. A=FFF6, B=FFF1, CTRL=0 -> S=FFE7, C_OUT=1, OVF=0, NEG=1.
3. Subtract: A=0003, B=0008, CTRL=1 -> S=FFFB, C_OUT=0, NEG=1. A=0008, B=0008, CTRL=1 -> S=0000, ZERO=1, C_OUT=1.
4. Handshake: assert START with A=1234 while in RUN -> ignored, result unchanged. Hold ACK=0 for 5 cycles -> VALID and S stable. ACK=1 -> VALID=0 and READY=1 next cycle. Back-to-back ops with an ACK/START pair complete correctly.
5. Reset mid-operation: RST_N low two cycles after acceptance -> READY=1, VALID=0, S=0 asynchronously. After release, a new op A=0002, B=0002 gives S=0004.
6. Parametrisation: WIDTH=32, CHUNK=8: FFFFFFFF+00000001 -> after 4 edges S=00000000, C_OUT=1, ZERO=1, OVF=0. WIDTH=16, CHUNK=16 -> latency 1 edge, same results as scenario 1.
